// File: rtl/watch_display_if.sv
// watch_display_if: BCD digits from the watch block plus the display pins.
// master drives digits and observes pins; slave is the display driver.
interface watch_display_if;
  logic [3:0] Hour1;
  logic [3:0] Hour2;
  logic [3:0] Min1;
  logic [3:0] Min2;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  modport master (
    output Hour1, Hour2, Min1, Min2,
    input  an_n, seg_n, dp_n
  );

  modport slave (
    input  Hour1, Hour2, Min1, Min2,
    output an_n, seg_n, dp_n
  );
endinterface

// File: rtl/watch_display.sv
// watch_display: 4-digit multiplexed HH:MM common-anode seven-segment driver.
// Ports: clk, rst_n (async, active-low), dsp (watch_display_if.slave:
//   Hour1/Hour2/Min1/Min2 BCD in; an_n[3:0], seg_n[6:0] {g..a}, dp_n out).
// Option: define WATCH_DISP_BLANK_LZ_EN to blank a leading hours zero.
module watch_display #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic      clk,
  input  logic      rst_n,
  watch_display_if.slave dsp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]  pre_q, pre_d;
  logic [1:0]     sel_q, sel_d;
  logic           started_q, started_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
  logic           colon_q, colon_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;

  logic       tick;
  logic       wrap;
  logic [3:0] digit;
  logic       bad;
  logic [6:0] seg_dec;

  assign tick = (pre_q == PW'(SCAN_DIV - 1));
  assign wrap = tick && (sel_q == 2'd3);

  always_comb begin
    pre_d       = tick ? '0 : pre_q + PW'(1);
    sel_d       = tick ? sel_q + 2'd1 : sel_q;
    started_d   = started_q | tick;
    snap_d      = snap_q;
    frame_cnt_d = frame_cnt_q;
    colon_d     = colon_q;
    if (wrap) begin
      snap_d = {dsp.Min2, dsp.Min1, dsp.Hour2, dsp.Hour1};
    end
    // The start-up wrap opens frame 0 and is not counted.
    if (wrap && started_q) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        colon_d     = ~colon_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    digit = snap_q[sel_q];
    bad   = (digit > 4'd9)
         || ((sel_q == 2'd0) && (digit > 4'd2))
         || ((sel_q == 2'd2) && (digit > 4'd5));
    unique case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase
    if (bad) seg_dec = 7'b0111111;
`ifdef WATCH_DISP_BLANK_LZ_EN
    if ((sel_q == 2'd0) && (digit == 4'd0)) seg_dec = 7'b1111111;
`else
    seg_dec = seg_dec;
`endif
  end

  // Pins are computed from already-registered scan state, so anode
  // and segment changes land on the same edge.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (started_q) begin
      an_d  = ~(4'b0001 << sel_q);
      seg_d = seg_dec;
      dp_d  = ~(colon_q && (sel_q == 2'd1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      sel_q       <= 2'd3;
      started_q   <= 1'b0;
      snap_q      <= '0;
      frame_cnt_q <= '0;
      colon_q     <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      pre_q       <= pre_d;
      sel_q       <= sel_d;
      started_q   <= started_d;
      snap_q      <= snap_d;
      frame_cnt_q <= frame_cnt_d;
      colon_q     <= colon_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign dsp.an_n  = an_q;
  assign dsp.seg_n = seg_q;
  assign dsp.dp_n  = dp_q;

endmodule

// File: tb/tb_watch_display.sv
// tb_watch_display: randomized, model-checked bench for watch_display.
// Uses SCAN_DIV=4, BLINK_FRAMES=2.
module tb_watch_display;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 4 * SD;
  localparam logic [11:0] BLANK = {4'hF, 7'h7F, 1'b1};
  localparam logic [6:0] SEGTAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [15:0] hist [0:4095];
  logic [11:0] obs, expv;

  watch_display_if bus();

  watch_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dsp(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model(int e);
    int k, slot, f, lim;
    logic [15:0] s;
    logic [3:0] d, an;
    logic [6:0] sg;
    logic dp;
    if (e < SD + 1) return BLANK;
    k = e - SD - 1;
    slot = (k / SD) % 4;
    f = k / FR;
    s = hist[SD + f * FR];
    d = s[15 - 4 * slot -: 4];
    lim = (slot == 0) ? 2 : (slot == 2) ? 5 : 9;
    sg = (int'(d) > lim) ? 7'b0111111 : SEGTAB[d];
`ifdef WATCH_DISP_BLANK_LZ_EN
    if (slot == 0 && d == 4'd0) sg = 7'h7F;
`endif
    an = 4'b1111;
    an[slot] = 1'b0;
    dp = !(((f / BF) % 2 == 1) && slot == 1);
    return {an, sg, dp};
  endfunction

  function automatic int slot_of(int e);
    return ((e - SD - 1) / SD) % 4;
  endfunction

  function automatic int frame_of(int e);
    return (e - SD - 1) / FR;
  endfunction

  task automatic set_in(input logic [3:0] a, b, c, d);
    bus.Hour1 = a;
    bus.Hour2 = b;
    bus.Min1 = c;
    bus.Min2 = d;
  endtask

  task automatic step();
    if (n < 4094) hist[n + 1] = {bus.Hour1, bus.Hour2, bus.Min1, bus.Min2};
    @(posedge clk);
    #1;
    n++;
    obs = {bus.an_n, bus.seg_n, bus.dp_n};
    expv = model(n);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      obs = {bus.an_n, bus.seg_n, bus.dp_n};
      checks++;
      if (obs !== BLANK) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got %h expected %h", i, obs, BLANK);
      end
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL post_release n=%0d got %h expected %h", n, obs, expv);
      end
    end
  endtask

  task automatic test_scan();
    apply_reset();
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 6 * FR + SD + 1; i++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL scan_colon n=%0d got %h expected %h", n, obs, expv);
      end
    end
  endtask

  task automatic test_snapshot();
    int fchg;
    apply_reset();
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    do begin
      step();
    end while (!(n > SD + FR && slot_of(n) == 1));
    fchg = frame_of(n);
    bus.Min2 = 4'd7;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL snapshot n=%0d got %h expected %h", n, obs, expv);
      end
      if (slot_of(n) == 3) begin
        checks++;
        if (frame_of(n) == fchg && bus.seg_n !== 7'b0011001) begin
          errors++;
          $display("FAIL snap_old n=%0d got %b expected 0011001", n, bus.seg_n);
        end
        if (frame_of(n) == fchg + 1 && bus.seg_n !== 7'b1111000) begin
          errors++;
          $display("FAIL snap_new n=%0d got %b expected 1111000", n, bus.seg_n);
        end
      end
    end
  endtask

  task automatic test_range();
    apply_reset();
    set_in(4'd3, 4'd5, 4'd2, 4'd8);
    for (int i = 0; i < 2 * FR + SD + 1; i++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL range_h1 n=%0d got %h expected %h", n, obs, expv);
      end
      if (n > SD && slot_of(n) == 0) begin
        checks++;
        if (bus.seg_n !== 7'b0111111) begin
          errors++;
          $display("FAIL dash_h1 n=%0d got %b expected 0111111", n, bus.seg_n);
        end
      end
    end
    set_in(4'd1, 4'd9, 4'hA, 4'd6);
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL range_m1 n=%0d got %h expected %h", n, obs, expv);
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] want;
`ifdef WATCH_DISP_BLANK_LZ_EN
    want = 7'h7F;
`else
    want = 7'b1000000;
`endif
    apply_reset();
    set_in(4'd0, 4'd7, 4'd5, 4'd9);
    for (int i = 0; i < 2 * FR + SD + 1; i++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL lz n=%0d got %h expected %h", n, obs, expv);
      end
      if (n > SD && slot_of(n) == 0) begin
        checks++;
        if (bus.seg_n !== want) begin
          errors++;
          $display("FAIL lz_slot0 n=%0d got %b expected %b", n, bus.seg_n, want);
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    set_in(4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)));
    for (int i = 0; i < 10 * FR; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        else
          set_in(4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)));
      end
      step();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random n=%0d got %h expected %h", n, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_in(4'd2, 4'd3, 4'd4, 4'd5);
    for (int i = 0; i < FR + SD + 3; i++) step();
    #3;
    rst_n = 1'b0;
    #1;
    obs = {bus.an_n, bus.seg_n, bus.dp_n};
    checks++;
    if (obs !== BLANK) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", obs, BLANK);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL restart n=%0d got %h expected %h", n, obs, expv);
      end
    end
  endtask

  initial begin
    set_in(4'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_scan();
    test_snapshot();
    test_range();
    test_lz();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_display.md
# watch_display

Four-digit multiplexed seven-segment driver that consumes the BCD time digits produced by the `watch` block (`Hour1`, `Hour2`, `Min1`, `Min2`) and scans them onto a common-anode HH:MM display. It latches a tear-free snapshot of all four digits once per scan frame, decodes BCD to segments, flags out-of-range digits with a dash, and blinks the colon. It sits between `watch` and the board pins in the same single clock domain.

## Interface

- `SCAN_DIV`, 1000: clock cycles per digit slot; must be ≥ 2.
- `BLINK_FRAMES`, 125: full scan frames per colon half-period; must be ≥ 1.

- `clk`  in  1  system clock, same as `watch`.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `Hour1`  in  4  hours tens digit, BCD, valid range 0–2.
- `Hour2`  in  4  hours units digit, BCD, valid range 0–9.
- `Min1`  in  4  minutes tens digit, BCD, valid range 0–5.
- `Min2`  in  4  minutes units digit, BCD, valid range 0–9.
- `an_n`  out  4  active-low digit enables; `an_n[0]` selects `Hour1` and `an_n[3]` selects `Min2`.
- `seg_n`  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- `dp_n`  out  1  active-low colon; driven only in the digit-1 (`Hour2`) slot.

## Operation

- **Prescaler `pre`:** counts 0..SCAN_DIV-1 and then wraps to 0. A tick is the cycle in which `pre == SCAN_DIV-1`.
- **Digit select `sel` (2 bits):** advances once per tick through 0→1→2→3→0. It resets to 3, so the first tick moves it to 0.
- **`started` flag:** set on the first tick. While it is 0, all outputs stay blank.
- **Snapshot:** on every tick that moves `sel` to 0, all four inputs are registered together. The whole frame displays this snapshot. Input changes mid-frame do not appear until the next frame.
- **Decode of snapshot digit `d` for slot `sel`:**
  - 0→7'b1000000, 1→7'b1111001, 2→7'b0100100, 3→7'b0110000, 4→7'b0011001
  - 5→7'b0010010, 6→7'b0000010, 7→7'b1111000, 8→7'b0000000, 9→7'b0010000
- **Range check:** an out-of-range digit shows a dash, 7'b0111111. Out of range means any digit > 9, `Hour1` > 2, or `Min1` > 5.
- **Anodes:** `an_n = ~(4'b0001 << sel)` once `started` is set.
- **Colon:**
  - `frame_cnt` increments on each wrap of `sel` to 0.
  - When `frame_cnt` reaches BLINK_FRAMES-1 and wraps, `colon_on` toggles.
  - `dp_n = ~(colon_on && sel == 1)`.
- **Reset values:**
  - `an_n = 4'b1111`, `seg_n = 7'b1111111`, `dp_n = 1`.
  - `pre = 0`, `sel = 3`, `frame_cnt = 0`, `colon_on = 0`, `started = 0`, snapshot = 0.

## Timing

- All outputs are registered. There is no combinational path from the inputs to the pins.
- **Edge E** is the edge that ends a tick cycle. On E: `pre` goes to 0, `sel` advances, the snapshot is taken if applicable, and `frame_cnt`/`colon_on` update.
- **Edge E+1:** `an_n`, `seg_n` and `dp_n` reflect the new `sel`, snapshot and colon state. This gives 2-cycle latency from the tick cycle to the pins.
- **Digit dwell** is exactly SCAN_DIV cycles; the frame period is 4·SCAN_DIV cycles.
- **First visible digit** after `rst_n` rises is at edge SCAN_DIV+1.
- **Ghosting guard:** `an_n` and `seg_n` change on the same edge. Only one anode is ever low.
- **Reset mid-frame:** `rst_n` low blanks all outputs immediately (asynchronous) and clears all state. Scanning restarts from the first-tick condition.
- **Colon period:** one colon half-period is BLINK_FRAMES frames. The first colon-on frame is frame index BLINK_FRAMES, counting from 0.

## Configuration

- Macro `WATCH_DISP_BLANK_LZ_EN`: blanks a leading hours zero.
- **Defined:** in slot 0, a snapshot `Hour1 == 0` drives `seg_n = 7'b1111111`. `an_n` still follows the normal rule; all other slots are unaffected.
- **Undefined:** `Hour1 == 0` displays 7'b1000000.

## Test plan

Benches use `SCAN_DIV = 4` and `BLINK_FRAMES = 2`.

- **Reset hold:** hold `rst_n = 0` for 10 cycles → `an_n = 4'hF`, `seg_n = 7'h7F`, `dp_n = 1` throughout. After release, outputs stay blank until edge 5.
- **Scan order:** inputs 1,2,3,4 → `an_n` sequences 1110, 1101, 1011, 0111, 4 cycles each. `seg_n` = 1111001, 0100100, 0110000, 0011001 in step, repeating.
- **Snapshot:** change `Min2` from 4 to 7 while `sel == 1` → slot 3 shows 0011001 in this frame and 1111000 in the next frame.
- **Range check:** `Hour1 = 3`, or `Min1 = 4'hA` → the corresponding slot shows 0111111. The other slots are unaffected.
- **Colon blink:** `dp_n = 1` in frames 0–1, `dp_n` low only during `sel == 1` in frames 2–3, high again in frames 4–5.
- **Leading zero:** `Hour1 = 0` gives slot 0 `seg_n = 7'h7F` with `WATCH_DISP_BLANK_LZ_EN` defined and 1000000 without it. Additionally, asserting `rst_n` mid-slot blanks the outputs in the same cycle.
